rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Runtime writer for the SoC instruction ROM: the hardware counterpart of bench-side ROM preloading.
- Accepts a framed byte stream on a valid/ready input, normally driven by a UART receiver.
- Assembles 32-bit little-endian instruction words, writes them sequentially into the ROM write port, and verifies a checksum.
- Holds the core in reset until a load succeeds.

Parameters:
- ADDR_WIDTH, 12, ROM word-address width; capacity = 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 100000, consecutive idle cycles allowed mid-frame before the frame is aborted.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  byte available
- in_data  input  8  byte value
- in_ready  output  1  loader can accept a byte
- rom_we  output  1  ROM write strobe, one cycle per word
- rom_waddr  output  ADDR_WIDTH  ROM word address
- rom_wdata  output  32  ROM write data
- core_hold  output  1  1 = core must be held in reset
- done  output  1  load completed with good checksum (sticky)
- error  output  1  last frame failed
- word_cnt  output  ADDR_WIDTH+1  words written in current/last frame

Behaviour:
- Reset is synchronous and active-high on rst.
- Reset values: state=SYNC, core_hold=1, rom_we=0, rom_waddr=0, rom_wdata=0, done=0, error=0, word_cnt=0, in_ready=1.
- Byte accepted in a cycle where in_valid && in_ready.
- in_ready = 1 in every state except DONE.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN*4 data bytes, then CSUM.
  - LEN is a 16-bit word count.
  - CSUM = 8-bit modulo-256 sum of the data bytes only.
- States:
  - SYNC: non-SYNC_BYTE bytes discarded. SYNC_BYTE -> LEN_LO; clear word_cnt, byte index, running sum; clear error.
  - LEN_LO: capture low byte -> LEN_HI.
  - LEN_HI: capture high byte.
    - LEN > 2^ADDR_WIDTH -> ERR.
    - LEN = 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: byte k of each word goes to bits [8k+7:8k]; running sum accumulates.
    - On the 4th byte, next cycle: rom_we=1, rom_wdata=assembled word, rom_waddr=word_cnt[ADDR_WIDTH-1:0].
    - word_cnt increments in that same write cycle.
    - After the write of word LEN-1 -> CSUM.
    - Write latency: exactly 1 cycle after the accepting edge; rom_we is never high for two consecutive cycles.
  - CSUM: byte == running sum -> DONE; otherwise -> ERR.
  - DONE: done=1, core_hold=0, in_ready=0. Sticky until rst.
  - ERR: error=1, core_hold=1. SYNC_BYTE starts a new frame as in SYNC (error clears); other bytes discarded.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CSUM, an idle counter clears on every accepted byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - A partially assembled word is dropped and never written.
- Rewrites: ROM contents written before an ERR are not rolled back; the next good frame overwrites from address 0.
- Mid-frame rst: everything returns to reset values; no rom_we in the cycle after rst.
- core_hold transitions 1->0 only on entry to DONE.

Test Plan:
- Normal load:
  - Stimulus: A5 02 00 13 05 10 00 93 05 20 00 E0.
  - Required: write addr0 = 0x00100513, then addr1 = 0x00200593, each 1 cycle after its 4th byte; done=1, core_hold=0, word_cnt=2, in_ready=0.
- Bad checksum:
  - Stimulus: same frame with final byte E1.
  - Required: both words written, error=1, core_hold=1, done=0.
  - Retry: resend the full correct frame -> error=0, done=1.
- Leading garbage / zero length:
  - Stimulus: 00 FF 5A A5 00 00 00.
  - Required: garbage ignored, no rom_we; done=1, word_cnt=0.
- Oversize length:
  - Stimulus: A5 01 10 (LEN=0x1001, ADDR_WIDTH=12).
  - Required: error=1 on the cycle after LEN_HI is accepted, no rom_we.
  - Repeat with LEN=0x1000: DATA state entered.
- Timeout:
  - Stimulus: A5 01 00 13 05 10, then in_valid=0 for TIMEOUT_CYCLES cycles (bench uses TIMEOUT_CYCLES=16).
  - Required: error=1 after exactly 16 idle cycles; rom_we never asserted.
- Reset mid-frame:
  - Stimulus: rst=1 for 1 cycle after 2 data bytes.
  - Required: all outputs at reset values next cycle; a subsequent full frame loads from addr0 correctly.
- Backpressure:
  - Stimulus: after DONE, hold in_valid=1.
  - Required: in_ready=0; no state change, no writes.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: framed byte-stream loader that writes 32-bit words into the instruction ROM and releases the core on a good checksum
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_data/in_ready  byte stream in (valid/ready handshake)
//   rom_we/rom_waddr/rom_wdata ROM write port, one strobe per assembled word
//   core_hold              1 until a frame loads with a good checksum
//   done, error            sticky success / last frame failed
//   word_cnt               words written in the current or last frame
module rom_loader #(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_waddr,
    output logic [31:0]           rom_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_cnt
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_WIDTH;
    typedef enum logic [2:0] {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            sum_q, sum_d;
    logic [23:0]           asm_q, asm_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]           rom_wdata_q, rom_wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  core_hold_q, core_hold_d;
    logic                  in_ready_q, in_ready_d;
    logic                  acc, timed;
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        sum_d       = sum_q;
        asm_d       = asm_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        acc         = in_valid && in_ready_q;
        timed       = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
        idle_d      = (acc || !timed) ? '0 : idle_q + 1'b1;
        if (acc) begin
            case (state_q)
                S_SYNC, S_ERR: if (in_data == SYNC_BYTE) begin
                    state_d    = S_LEN_LO;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    sum_d      = '0;
                end
                S_LEN_LO: begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d[15:8] = in_data;
                    state_d = ({1'b0, in_data, len_q[7:0]} > LEN_MAX) ? S_ERR :
                              ({in_data, len_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    sum_d      = sum_q + in_data;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q != 2'd3) asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    else begin
                        // Write strobe is registered, so it appears exactly one cycle after the 4th byte
                        rom_we_d    = 1'b1;
                        rom_wdata_d = {in_data, asm_q};
                        rom_waddr_d = word_cnt_q[ADDR_WIDTH-1:0];
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (16'(word_cnt_q) + 16'd1 == len_q) state_d = S_CSUM;
                    end
                end
                S_CSUM: state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                default: ;
            endcase
        end
        // idle_d is zero whenever a byte was accepted, so this only fires on a true stall
        if (timed && idle_d == IW'(TIMEOUT_CYCLES)) state_d = S_ERR;
        done_d      = state_d == S_DONE;
        error_d     = state_d == S_ERR;
        core_hold_d = state_d != S_DONE;
        in_ready_d  = state_d != S_DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SYNC;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            sum_q       <= '0;
            asm_q       <= '0;
            idle_q      <= '0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            core_hold_q <= 1'b1;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            sum_q       <= sum_d;
            asm_q       <= asm_d;
            idle_q      <= idle_d;
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            core_hold_q <= core_hold_d;
            in_ready_q  <= in_ready_d;
        end
    end
    assign in_ready  = in_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign error     = error_q;
    assign word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven directed bench for rom_loader plus a hand-written timeout sequence
module tb_rom_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, rom_we, core_hold, done, error;
    logic [11:0] rom_waddr;
    logic [31:0] rom_wdata;
    logic [12:0] word_cnt;
    int          tests = 0;
    int          fails = 0;
    rom_loader #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .core_hold(core_hold),
        .done(done), .error(error), .word_cnt(word_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        r, v;
        logic [7:0]  d;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        dn, er;
        logic [12:0] cnt;
    } vec_t;
    vec_t vq[$];
    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic we,
                       input logic [11:0] addr, input logic [31:0] wdata, input logic dn,
                       input logic er, input logic [12:0] cnt);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.we = we; x.addr = addr; x.wdata = wdata;
        x.dn = dn; x.er = er; x.cnt = cnt;
        vq.push_back(x);
    endtask
    task automatic rst_vec();
        add(1, 0, 8'h00, 0, 12'h0, 32'h0, 0, 0, 0);
    endtask
    // A5 02 00 | 13 05 10 00 | 93 05 20 00 | cs ; data sum is 0xE0
    task automatic frame(input logic [7:0] cs, input logic good);
        add(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h02, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h13, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h05, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h10, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 1, 12'h000, 32'h00100513, 0, 0, 1);
        add(0, 1, 8'h93, 0, 0, 0, 0, 0, 1);
        add(0, 1, 8'h05, 0, 0, 0, 0, 0, 1);
        add(0, 1, 8'h20, 0, 0, 0, 0, 0, 1);
        add(0, 1, 8'h00, 1, 12'h001, 32'h00200593, 0, 0, 2);
        add(0, 1, cs, 0, 0, 0, good, !good, 2);
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst = r; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask
    initial begin
        // reset and normal load, then backpressure while DONE
        rst_vec();
        frame(8'hE0, 1);
        repeat (3) add(0, 1, 8'hA5, 0, 0, 0, 1, 0, 2);
        // bad checksum then retry with the correct frame
        rst_vec();
        frame(8'hE1, 0);
        frame(8'hE0, 1);
        // leading garbage and zero length
        rst_vec();
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h5A, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 1, 0, 0);
        // oversize length 0x1001 errors, then 0x1000 enters DATA and writes a word
        rst_vec();
        add(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h01, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h10, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h33, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h10, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h01, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h77, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h02, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h03, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h04, 1, 12'h000, 32'h04030201, 0, 0, 1);
        add(0, 1, 8'h05, 0, 0, 0, 0, 0, 1);
        // reset mid-frame after two data bytes, then a clean load from address 0
        rst_vec();
        add(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h01, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h13, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h05, 0, 0, 0, 0, 0, 0);
        rst_vec();
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        frame(8'hE0, 1);
        foreach (vq[i]) begin
            step(vq[i].r, vq[i].v, vq[i].d);
            chk($sformatf("v%0d.we", i), rom_we, vq[i].we);
            chk($sformatf("v%0d.done", i), done, vq[i].dn);
            chk($sformatf("v%0d.error", i), error, vq[i].er);
            chk($sformatf("v%0d.hold", i), core_hold, !vq[i].dn);
            chk($sformatf("v%0d.ready", i), in_ready, !vq[i].dn);
            chk($sformatf("v%0d.cnt", i), word_cnt, vq[i].cnt);
            if (vq[i].we || vq[i].r) begin
                chk($sformatf("v%0d.waddr", i), rom_waddr, vq[i].addr);
                chk($sformatf("v%0d.wdata", i), rom_wdata, vq[i].wdata);
            end
        end
        // timeout: 3 data bytes of a 1-word frame, then 16 idle cycles
        step(1, 0, 8'h00);
        step(0, 1, 8'hA5);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'h13);
        step(0, 1, 8'h05);
        step(0, 1, 8'h10);
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, 8'h00);
            chk($sformatf("to%0d.error", k), error, 1'b0);
            chk($sformatf("to%0d.we", k), rom_we, 1'b0);
        end
        step(0, 0, 8'h00);
        chk("to16.error", error, 1'b1);
        chk("to16.hold", core_hold, 1'b1);
        chk("to16.we", rom_we, 1'b0);
        chk("to16.ready", in_ready, 1'b1);
        step(0, 1, 8'h00);
        chk("to_err_discard.error", error, 1'b1);
        chk("to_err_discard.we", rom_we, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
